// File: rtl/fire_pkg.sv
// rtl/fire_pkg.sv - shared state encoding, sensor indices and vote helper for the fire event path
package fire_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALARM   = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   // Bit positions of each sensor inside the packed 3-bit sensor vector
   localparam int IDX_TEMP  = 2;
   localparam int IDX_SMOKE = 1;
   localparam int IDX_HUM   = 0;

   // 2-of-3 majority of the packed sensor vector
   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/sensor_fault_tracker.sv
// rtl/sensor_fault_tracker.sv - per-sensor disagreement counter with sticky fault flag
module sensor_fault_tracker #(
   parameter int FAULT_M = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sensor_i,
   input  logic vote_i,
   input  logic tick_i,
   input  logic clear_i,
   output logic flag_o
);

   localparam int FW = $clog2(FAULT_M + 1);

   logic [FW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          set_evt;

   // Count consecutive disagreeing ticks (saturating); a set event beats a clear request
   always_comb begin
      cnt_d   = cnt_q;
      set_evt = 1'b0;
      if (tick_i) begin
         if (sensor_i != vote_i) begin
            if (cnt_q != FW'(FAULT_M)) cnt_d = cnt_q + 1'b1;
            set_evt = (cnt_d == FW'(FAULT_M));
         end else begin
            cnt_d = '0;
         end
      end
      if (set_evt)      flag_d = 1'b1;
      else if (clear_i) flag_d = 1'b0;
      else              flag_d = flag_q;
   end

   // Register the counter and sticky flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/fire_event_controller.sv
// rtl/fire_event_controller.sv - three-sensor majority-vote fire event sequencer
module fire_event_controller
   import fire_pkg::*;
#(
   parameter int PRESCALE  = 4,
   parameter int CONFIRM_N = 3,
   parameter int FAULT_M   = 4,
   parameter int HOLD_T    = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             temperature,
   input  logic             smoke,
   input  logic             humidity,
   input  logic             ack,
   input  logic             clear_faults,
   output logic             alarm,
   output logic             trusted,
   output logic [2:0]       fault_flag,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] event_count
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(CONFIRM_N + 1);
   localparam int HW = $clog2(HOLD_T + 1);

   logic [2:0]       sens_raw;
   logic [2:0]       sync_meta_q, sync_q;
   logic [PW-1:0]    pre_q;
   logic             tick, vote, agree, confirm_hit;
   state_e           state_q;
   logic [CW-1:0]    confirm_q, confirm_next;
   logic [HW-1:0]    hold_q, hold_next;
   logic             alarm_q, trusted_q;
   logic [CNT_W-1:0] event_count_q;

   assign sens_raw[IDX_TEMP]  = temperature;
   assign sens_raw[IDX_SMOKE] = smoke;
   assign sens_raw[IDX_HUM]   = humidity;

   // Two-flop synchronizer for the asynchronous sensor bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_q <= '0;
         sync_q      <= '0;
      end else begin
         sync_meta_q <= sens_raw;
         sync_q      <= sync_meta_q;
      end
   end

   assign tick  = enable && (pre_q == PW'(PRESCALE - 1));
   assign vote  = majority3(sync_q);
   assign agree = (sync_q == 3'b000) || (sync_q == 3'b111);

   // Sample-tick prescaler, held at zero while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                pre_q <= '0;
      else if (!enable || tick)  pre_q <= '0;
      else                       pre_q <= pre_q + 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_fault
         sensor_fault_tracker #(.FAULT_M(FAULT_M)) u_trk (
            .clk      (clk),
            .rst_n    (rst_n),
            .sensor_i (sync_q[gi]),
            .vote_i   (vote),
            .tick_i   (tick),
            .clear_i  (clear_faults),
            .flag_o   (fault_flag[gi])
         );
      end
   endgenerate

   assign confirm_next = confirm_q + 1'b1;
   assign hold_next    = hold_q + 1'b1;
   assign confirm_hit  = tick && vote &&
                         (((state_q == ST_IDLE) && (CONFIRM_N == 1)) ||
                          ((state_q == ST_PENDING) && (confirm_next == CW'(CONFIRM_N))));

   // Sequencing FSM with registered alarm, trust tag and saturating event count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         confirm_q     <= '0;
         hold_q        <= '0;
         alarm_q       <= 1'b0;
         trusted_q     <= 1'b0;
         event_count_q <= '0;
      end else if (!enable) begin
         state_q   <= ST_IDLE;
         confirm_q <= '0;
         hold_q    <= '0;
         alarm_q   <= 1'b0;
         trusted_q <= 1'b0;
      end else if (confirm_hit) begin
         state_q   <= ST_ALARM;
         confirm_q <= '0;
         alarm_q   <= 1'b1;
         trusted_q <= agree;
         if (event_count_q != '1) event_count_q <= event_count_q + 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick && vote) begin
                  state_q   <= ST_PENDING;
                  confirm_q <= CW'(1);
               end
            end
            ST_PENDING: begin
               if (tick) begin
                  if (vote) begin
                     confirm_q <= confirm_next;
                  end else begin
                     state_q   <= ST_IDLE;
                     confirm_q <= '0;
                  end
               end
            end
            ST_ALARM: begin
               if (ack) begin
                  state_q   <= ST_HOLD;
                  hold_q    <= '0;
                  alarm_q   <= 1'b0;
                  trusted_q <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  if (vote) begin
                     hold_q <= '0;
                  end else if (hold_next == HW'(HOLD_T)) begin
                     state_q <= ST_IDLE;
                     hold_q  <= '0;
                  end else begin
                     hold_q <= hold_next;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alarm       = alarm_q;
   assign trusted     = trusted_q;
   assign state_o     = state_q;
   assign event_count = event_count_q;

endmodule

// File: tb/tb_fire_event_controller.sv
// tb/tb_fire_event_controller.sv - randomized self-checking bench with behavioural reference model
module tb_fire_event_controller;

   localparam int P  = 4;
   localparam int CN = 3;
   localparam int FM = 4;
   localparam int HT = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          temperature = 1'b0;
   logic          smoke = 1'b0;
   logic          humidity = 1'b0;
   logic          ack = 1'b0;
   logic          clear_faults = 1'b0;
   logic          alarm, trusted;
   logic [2:0]    fault_flag;
   logic [1:0]    state_o;
   logic [CW-1:0] event_count;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   fire_event_controller #(
      .PRESCALE(P), .CONFIRM_N(CN), .FAULT_M(FM), .HOLD_T(HT), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .temperature(temperature), .smoke(smoke), .humidity(humidity),
      .ack(ack), .clear_faults(clear_faults),
      .alarm(alarm), .trusted(trusted), .fault_flag(fault_flag),
      .state_o(state_o), .event_count(event_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sensor pipeline as a 2-deep delay, votes by popcount, counters as integers
   int       m_phase = 0, m_st = 0, m_run = 0, m_low = 0, m_cnt = 0;
   int       m_fc [3] = '{0, 0, 0};
   bit [2:0] m_flag = 3'b000;
   bit       m_alarm = 1'b0, m_trust = 1'b0;
   bit [2:0] m_d1 = 3'b000, m_d2 = 3'b000;

   always @(posedge clk) begin : model
      bit [2:0] s;
      bit       tk, vt, ag;
      if (!rst_n) begin
         m_phase = 0; m_st = 0; m_run = 0; m_low = 0; m_cnt = 0;
         m_fc = '{0, 0, 0}; m_flag = 3'b000; m_alarm = 1'b0; m_trust = 1'b0;
         m_d1 = 3'b000; m_d2 = 3'b000;
      end else begin
         s  = m_d2;
         tk = enable && (m_phase == P - 1);
         vt = ($countones(s) >= 2);
         ag = (s == 3'b000) || (s == 3'b111);
         m_phase = (!enable || tk) ? 0 : m_phase + 1;
         for (int i = 0; i < 3; i++) begin
            bit setf;
            setf = 1'b0;
            if (tk) begin
               if (s[i] != vt) begin
                  m_fc[i] = (m_fc[i] + 1 > FM) ? FM : m_fc[i] + 1;
                  setf = (m_fc[i] == FM);
               end else begin
                  m_fc[i] = 0;
               end
            end
            if (setf)              m_flag[i] = 1'b1;
            else if (clear_faults) m_flag[i] = 1'b0;
         end
         if (!enable) begin
            m_st = 0; m_run = 0; m_low = 0; m_alarm = 1'b0; m_trust = 1'b0;
         end else if (m_st == 2) begin
            if (ack) begin m_st = 3; m_low = 0; m_alarm = 1'b0; m_trust = 1'b0; end
         end else if (m_st == 3) begin
            if (tk) begin
               m_low = vt ? 0 : m_low + 1;
               if (m_low == HT) begin m_st = 0; m_low = 0; end
            end
         end else if (tk) begin
            // IDLE/PENDING: length of the current run of majority-high ticks
            m_run = vt ? m_run + 1 : 0;
            if (m_run >= CN) begin
               m_st = 2; m_run = 0; m_alarm = 1'b1; m_trust = ag;
               if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else begin
               m_st = (m_run > 0) ? 1 : 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = {temperature, smoke, humidity};
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on && rst_n) begin
         check("alarm", alarm, m_alarm);
         check("trusted", trusted, m_trust);
         check("fault_flag", fault_flag, m_flag);
         check("state", state_o, m_st);
         check("event_count", event_count, m_cnt);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_s(input logic [2:0] v);
      {temperature, smoke, humidity} = v;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
   endtask

   initial begin
      cyc(3);
      check("rst_alarm", alarm, 0);
      check("rst_trusted", trusted, 0);
      check("rst_fault", fault_flag, 0);
      check("rst_state", state_o, 0);
      check("rst_count", event_count, 0);
      rst_n = 1'b1; enable = 1'b1; chk_on = 1'b1;

      // Confirmed trusted event, acknowledge, then drain HOLD
      set_s(3'b111); cyc(20);
      check("ev1_alarm", alarm, 1);
      check("ev1_trusted", trusted, 1);
      check("ev1_count", event_count, 1);
      check("ev1_state", state_o, 2);
      pulse_ack();
      check("ack_state", state_o, 3);
      check("ack_alarm", alarm, 0);
      set_s(3'b000); cyc(40);
      check("hold_done", state_o, 0);

      // Single high tick is rejected
      set_s(3'b111); cyc(4); set_s(3'b000); cyc(20);
      check("glitch_state", state_o, 0);
      check("glitch_count", event_count, 1);

      // Smoke disagrees: untrusted alarm and smoke fault
      set_s(3'b101); cyc(24);
      check("flt_alarm", alarm, 1);
      check("flt_trusted", trusted, 0);
      check("flt_flag", fault_flag, 3'b010);
      check("flt_count", event_count, 2);
      pulse_ack(); set_s(3'b000); cyc(12);
      clear_faults = 1'b1; cyc(1); clear_faults = 1'b0;
      check("flt_clear", fault_flag, 3'b000);
      cyc(40);
      check("flt_idle", state_o, 0);

      // HOLD restart: a high tick in HOLD restarts the low-tick count
      set_s(3'b111); cyc(20);
      check("hr_count", event_count, 3);
      pulse_ack(); set_s(3'b000); cyc(20);
      set_s(3'b111); cyc(4); set_s(3'b000); cyc(24);
      check("hr_still_hold", state_o, 3);
      cyc(16);
      check("hr_idle", state_o, 0);
      check("hr_count2", event_count, 3);

      // Two more events: count saturates at 3
      repeat (2) begin
         set_s(3'b111); cyc(20); pulse_ack(); set_s(3'b000); cyc(40);
      end
      check("sat_count", event_count, 3);
      pulse_ack();
      check("ack_idle", state_o, 0);

      // Humidity fault in IDLE, then disable while PENDING
      set_s(3'b001); cyc(24);
      check("hum_flag", fault_flag, 3'b001);
      set_s(3'b111); cyc(7);
      check("pend_state", state_o, 1);
      enable = 1'b0; cyc(1);
      check("dis_state", state_o, 0);
      check("dis_flag", fault_flag, 3'b001);
      enable = 1'b1;

      // Asynchronous reset during ALARM
      cyc(20);
      check("pre_rst_alarm", alarm, 1);
      rst_n = 1'b0; #1;
      check("arst_alarm", alarm, 0);
      check("arst_trusted", trusted, 0);
      check("arst_fault", fault_flag, 0);
      check("arst_count", event_count, 0);
      check("arst_state", state_o, 0);
      cyc(3); rst_n = 1'b1; set_s(3'b000);

      // Randomized traffic against the model
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) set_s(3'($urandom_range(0, 7)));
         ack = ($urandom_range(0, 15) == 0);
         clear_faults = ($urandom_range(0, 39) == 0);
         if (enable) enable = ($urandom_range(0, 299) != 0);
         else        enable = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
         else                              rst_n = 1'b1;
      end
      @(negedge clk);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fire_event_controller.md
Name: fire_event_controller

Overview:
- Sequencing controller for the three-sensor fire detection path (temperature, smoke, humidity).
- Samples the sensors on a prescaled tick and takes a 2-of-3 majority vote.
- Confirms an event only after persistence, tags it trusted when all three sensors agree, and tracks per-sensor faults.
- Holds the alarm until acknowledged, then enforces a cooldown; sits between the raw sensor bits and the alarm/reporting logic.

Parameters:
- PRESCALE, 4, clk cycles per sample tick (>=1)
- CONFIRM_N, 3, consecutive majority-high ticks required to raise alarm (>=1)
- FAULT_M, 4, consecutive ticks a sensor disagrees with the majority before it is flagged faulty (>=1)
- HOLD_T, 8, consecutive majority-low ticks required in HOLD before returning to IDLE (>=1)
- CNT_W, 8, width of event counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  controller enable
- temperature  in  1  raw temperature sensor bit, asynchronous
- smoke  in  1  raw smoke sensor bit, asynchronous
- humidity  in  1  raw humidity sensor bit, asynchronous
- ack  in  1  alarm acknowledge pulse
- clear_faults  in  1  clears sticky fault flags
- alarm  out  1  confirmed event active
- trusted  out  1  all three sensors agreed at the confirming tick
- fault_flag  out  3  sticky per-sensor fault; bit [2]=temperature, [1]=smoke, [0]=humidity
- state_o  out  2  current FSM state encoding
- event_count  out  CNT_W  number of confirmed events, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; state IDLE; all counters and synchronizers cleared.
- Input sync: each sensor passes through a 2-flop synchronizer before use. ack and clear_faults are synchronous inputs.
- Tick generation:
  - Prescale counter runs 0..PRESCALE-1 while enable=1; tick is asserted on the cycle the counter equals PRESCALE-1.
  - enable=0 clears the counter, forces IDLE, and clears confirm/hold counts. fault_flag and event_count are retained.
- Voting: vote = majority of the synchronized sensors; agree = all three equal. Both are evaluated only on tick.
- State encoding: IDLE=0, PENDING=1, ALARM=2, HOLD=3.
- IDLE:
  - tick with vote=1: go to PENDING with confirm_cnt=1.
  - If CONFIRM_N==1, go directly to ALARM instead.
- PENDING:
  - tick with vote=1: increment confirm_cnt; when it reaches CONFIRM_N, go to ALARM.
  - tick with vote=0: go to IDLE and clear confirm_cnt.
- Entry to ALARM (registered, takes effect the cycle after the confirming tick):
  - alarm=1.
  - trusted = agree at the confirming tick.
  - event_count increments, saturating at all-ones.
- ALARM:
  - Holds until ack=1, then goes to HOLD; alarm=0 and trusted=0 on the next cycle.
  - Ticks are ignored for state purposes. If ack and tick occur in the same cycle, ack wins.
- HOLD:
  - Each tick with vote=0 increments hold_cnt; a tick with vote=1 clears hold_cnt to 0.
  - hold_cnt reaching HOLD_T: go to IDLE.
  - No new alarm can be raised from HOLD.
- ack outside ALARM: ignored.
- Fault tracking, per sensor, on each tick in any state while enabled:
  - Sensor != vote: its counter increments, saturating at FAULT_M. Reaching FAULT_M sets fault_flag[i].
  - Sensor == vote: its counter clears.
  - fault_flag is sticky; it clears only on reset or clear_faults=1.
  - If clear_faults and a set event occur in the same cycle, set wins.
- Latency: from a sensor edge to alarm = 2 sync cycles + wait for the next tick + (CONFIRM_N-1)*PRESCALE + 1 cycle.
- Reset mid-operation: immediate return to reset values with no completion of the in-flight event.

Decomposition:
- Shared package fire_pkg holds:
  - state enum (IDLE, PENDING, ALARM, HOLD) and its 2-bit width constant;
  - sensor index constants (IDX_TEMP=2, IDX_SMOKE=1, IDX_HUM=0).
- One sub-module, sensor_fault_tracker (parameter FAULT_M), instantiated three times. Inputs: sensor bit, vote, tick, clear_faults. Output: sticky flag.
- Prescaler, voting and FSM stay in the top level.

Test Plan (defaults):
- Confirmed event: all sensors high for 3 ticks → alarm=1 one cycle after the 3rd tick; trusted=1, event_count=1; ack → alarm=0, state HOLD; 8 low ticks → IDLE.
- Glitch rejection: all sensors high for 1 tick, then low → state returns to IDLE; alarm never rises; event_count=0.
- Faulty sensor: temperature=1, humidity=1, smoke=0 for 4 ticks → alarm=1 with trusted=0; fault_flag=3'b010 after the 4th tick; clear_faults → 3'b000.
- Hold restart: after ack, 5 low ticks, 1 high tick, then 8 low ticks → IDLE only after the final 8th low tick; no second alarm and event_count unchanged.
- Reset and enable: rst_n=0 during ALARM → alarm, trusted, fault_flag, event_count and state_o read 0 immediately. enable=0 in PENDING → IDLE with fault_flag retained.
- Saturation, with CNT_W=2: 5 confirmed events → event_count stays 3. ack asserted in IDLE → no state change.
